// File: rtl/timer_pkg.sv
// Shared definitions for the start/pause/clear timer controller and the downstream countup.
// The state encoding is decoded outside this block, so it lives here.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        ILLEGAL = 2'd3
    } state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_CNT_W           = 20;

    // Start/pause toggle; anything unrecognised falls back to IDLE.
    function automatic state_e start_next(input state_e cur);
        state_e nxt;
        case (cur)
            IDLE:    nxt = RUN;
            RUN:     nxt = PAUSE;
            PAUSE:   nxt = RUN;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, saturating stability counter and press-edge detector
// for one raw bouncing pushbutton.
module btn_debounce
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic [CNT_W-1:0] cnt_r;

    // Metastability synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Accept the new level on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= CNT_ZERO;
        end else if (cnt_r >= CNT_LIMIT) begin
            level_r <= sync2_r;
            cnt_r   <= CNT_ZERO;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r   <= cnt_r + CNT_ONE;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_r;
        end
    end

    assign press = level_r & ~level_d_r;

endmodule

// File: rtl/timer_btn_ctrl.sv
// Start/pause/clear control FSM for a countup timer, driven by two debounced
// pushbuttons. All outputs come straight from flops.
module timer_btn_ctrl
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic       start,
    output logic       clr_pulse,
    output logic [1:0] state
);

    logic   start_ev_s;
    logic   clr_ev_s;
    state_e state_r;
    logic   start_r;
    logic   clr_pulse_r;
    state_e next_state_s;
    logic   next_start_s;
    logic   next_clr_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_start (
        .clk   (clk),
        .rst_n (reset),
        .btn   (btn_start),
        .press (start_ev_s)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_clear (
        .clk   (clk),
        .rst_n (reset),
        .btn   (btn_clear),
        .press (clr_ev_s)
    );

    // Next state: clear beats start, and the unused encoding recovers to IDLE.
    always_comb begin
        next_state_s = state_r;
        next_clr_s   = 1'b0;
        if (clr_ev_s) begin
            next_state_s = IDLE;
            next_clr_s   = 1'b1;
        end else if (start_ev_s) begin
            next_state_s = start_next(state_r);
        end else begin
            case (state_r)
                IDLE, RUN, PAUSE: next_state_s = state_r;
                default:          next_state_s = IDLE;
            endcase
        end
        next_start_s = (next_state_s == RUN) ? 1'b1 : 1'b0;
    end

    // State and output registers update together so start always tracks RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            start_r     <= 1'b0;
            clr_pulse_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            start_r     <= next_start_s;
            clr_pulse_r <= next_clr_s;
        end
    end

    assign state     = state_r;
    assign start     = start_r;
    assign clr_pulse = clr_pulse_r;

endmodule

// File: tb/tb_timer_btn_ctrl.sv
// Self-checking bench for timer_btn_ctrl with DEBOUNCE_CYCLES=4: directed scenarios
// plus a randomized run compared against a window-based behavioural model.
module tb_timer_btn_ctrl;
    import timer_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       start;
    logic       clr_pulse;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: index 0 = start button, 1 = clear button.
    bit m_s1   [2];
    bit m_s2   [2];
    bit m_lvl  [2];
    bit m_pend [2];
    bit m_win  [2][$];
    int m_state;
    bit m_clr;

    timer_btn_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .start     (start),
        .clr_pulse (clr_pulse),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0; m_pend[b] = 1'b0;
            m_win[b].delete();
        end
        m_state = 0;
        m_clr   = 1'b0;
    endtask

    // One clock edge of the behavioural model: a level flips once the last D
    // synchronized samples all disagree with it; a flip to 1 is a press event.
    task automatic model_step(input bit bs, input bit bc);
        bit in_b [2];
        bit ev   [2];
        bit all_diff;
        in_b[0] = bs;
        in_b[1] = bc;
        if (m_pend[1]) begin
            m_state = 0;
            m_clr   = 1'b1;
        end else begin
            m_clr = 1'b0;
            if (m_pend[0]) m_state = (m_state == 1) ? 2 : 1;
        end
        for (int b = 0; b < 2; b++) begin
            ev[b] = 1'b0;
            m_win[b].push_back(m_s2[b] != m_lvl[b]);
            if (m_win[b].size() > D) void'(m_win[b].pop_front());
            all_diff = (m_win[b].size() == D);
            foreach (m_win[b][i]) if (!m_win[b][i]) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl[b] = m_s2[b];
                m_win[b].delete();
                ev[b] = m_lvl[b];
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = in_b[b];
            m_pend[b] = ev[b];
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_step(btn_start, btn_clear);
        #1;
    endtask

    task automatic drive(input bit bs, input bit bc);
        @(negedge clk);
        btn_start = bs;
        btn_clear = bc;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0);
        repeat (n) step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL reset_start: got %0b expected 0", start); else n_pass++;
        n_checks++; if (clr_pulse !== 1'b0) $display("FAIL reset_clr: got %0b expected 0", clr_pulse); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_start_press();
        int clr_seen;
        clr_seen = 0;
        drive(1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (clr_pulse) clr_seen++;
            n_checks++;
            if (start !== (k >= 7 ? 1'b1 : 1'b0))
                $display("FAIL start_latency: cycle %0d got %0b expected %0b", k, start, (k >= 7));
            else n_pass++;
        end
        n_checks++; if (state !== 2'd1) $display("FAIL start_state: got %0d expected 1", state); else n_pass++;
        n_checks++; if (clr_seen !== 0) $display("FAIL start_no_clr: got %0d expected 0", clr_seen); else n_pass++;
        idle(10);
        n_checks++; if (state !== 2'd1) $display("FAIL release_no_event: got %0d expected 1", state); else n_pass++;
    endtask

    task automatic test_bounce();
        int trans;
        logic [1:0] prev;
        trans = 0;
        prev  = state;
        for (int i = 0; i < 20; i++) begin
            drive((i < 4) ? (i % 2 == 0) : 1'b1, 1'b0);
            step();
            if (state !== prev) trans++;
            prev = state;
        end
        n_checks++; if (trans !== 1) $display("FAIL bounce_transitions: got %0d expected 1", trans); else n_pass++;
        n_checks++; if (state !== 2'd2) $display("FAIL bounce_state: got %0d expected 2", state); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL bounce_start: got %0b expected 0", start); else n_pass++;
        idle(10);
    endtask

    task automatic test_pause_resume_clear();
        int clr_cnt;
        int clr_at;
        drive(1'b1, 1'b0);
        repeat (10) step();
        n_checks++; if (state !== 2'd1) $display("FAIL resume_state: got %0d expected 1", state); else n_pass++;
        idle(10);
        clr_cnt = 0;
        clr_at  = 0;
        drive(1'b0, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            step();
            if (clr_pulse) begin clr_cnt++; clr_at = k; end
        end
        n_checks++; if (clr_cnt !== 1) $display("FAIL clear_pulse_count: got %0d expected 1", clr_cnt); else n_pass++;
        n_checks++; if (clr_at !== 7) $display("FAIL clear_pulse_cycle: got %0d expected 7", clr_at); else n_pass++;
        n_checks++; if (state !== 2'd0) $display("FAIL clear_state: got %0d expected 0", state); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL clear_start: got %0b expected 0", start); else n_pass++;
        idle(10);
    endtask

    task automatic test_clear_in_idle();
        int clr_cnt;
        clr_cnt = 0;
        drive(1'b0, 1'b1);
        repeat (12) begin
            step();
            if (clr_pulse) clr_cnt++;
        end
        n_checks++; if (clr_cnt !== 1) $display("FAIL idle_clear_pulse: got %0d expected 1", clr_cnt); else n_pass++;
        n_checks++; if (state !== 2'd0) $display("FAIL idle_clear_state: got %0d expected 0", state); else n_pass++;
        idle(10);
    endtask

    task automatic test_simultaneous();
        int clr_cnt;
        bit saw_pause;
        drive(1'b1, 1'b0);
        repeat (10) step();
        n_checks++; if (state !== 2'd1) $display("FAIL simul_pre_run: got %0d expected 1", state); else n_pass++;
        idle(10);
        clr_cnt   = 0;
        saw_pause = 1'b0;
        drive(1'b1, 1'b1);
        repeat (12) begin
            step();
            if (clr_pulse) clr_cnt++;
            if (state == 2'd2) saw_pause = 1'b1;
        end
        n_checks++; if (clr_cnt !== 1) $display("FAIL simul_clr_count: got %0d expected 1", clr_cnt); else n_pass++;
        n_checks++; if (saw_pause !== 1'b0) $display("FAIL simul_no_pause: got %0b expected 0", saw_pause); else n_pass++;
        n_checks++; if (state !== 2'd0) $display("FAIL simul_state: got %0d expected 0", state); else n_pass++;
        idle(10);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0);
        repeat (10) step();
        idle(10);
        n_checks++; if (state !== 2'd1) $display("FAIL rstmid_pre_run: got %0d expected 1", state); else n_pass++;
        drive(1'b1, 1'b0);
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (state !== 2'd0) $display("FAIL rstmid_async_state: got %0d expected 0", state); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL rstmid_async_start: got %0b expected 0", start); else n_pass++;
        n_checks++; if (clr_pulse !== 1'b0) $display("FAIL rstmid_async_clr: got %0b expected 0", clr_pulse); else n_pass++;
        step();
        step();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= D + 3; k++) begin
            step();
            n_checks++;
            if (start !== (k == D + 3 ? 1'b1 : 1'b0))
                $display("FAIL rstmid_latency: cycle %0d got %0b expected %0b", k, start, (k == D + 3));
            else n_pass++;
        end
        n_checks++; if (state !== 2'd1) $display("FAIL rstmid_state: got %0d expected 1", state); else n_pass++;
        idle(10);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        force dut.state_r = ILLEGAL;
        #1;
        release dut.state_r;
        #1;
        n_checks++; if (state !== 2'd3) $display("FAIL illegal_forced: got %0d expected 3", state); else n_pass++;
        step();
        m_state = 0;
        n_checks++; if (state !== 2'd0) $display("FAIL illegal_recover: got %0d expected 0", state); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL illegal_start: got %0b expected 0", start); else n_pass++;
        idle(10);
    endtask

    task automatic test_random();
        bit bs;
        bit bc;
        int len;
        for (int seg = 0; seg < 120; seg++) begin
            bs  = ($urandom_range(0, 1) == 1);
            bc  = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 10);
            drive(bs, bc);
            repeat (len) begin
                step();
                n_checks++;
                if (state !== m_state[1:0]) $display("FAIL rand_state: got %0d expected %0d", state, m_state);
                else n_pass++;
                n_checks++;
                if (start !== (m_state == 1)) $display("FAIL rand_start: got %0b expected %0b", start, (m_state == 1));
                else n_pass++;
                n_checks++;
                if (clr_pulse !== m_clr) $display("FAIL rand_clr: got %0b expected %0b", clr_pulse, m_clr);
                else n_pass++;
            end
        end
        idle(10);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_press();
        test_bounce();
        test_pause_resume_clear();
        test_clear_in_idle();
        test_simultaneous();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_btn_ctrl.md
TIMER_BTN_CTRL -- requirements
Module: timer_btn_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable clk cycles required to accept a button level (10 ms at 100 MHz).
REQ-002 Parameter CNT_W, default 20, is the debounce counter width; it SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_start  input  1  raw start/pause pushbutton, asynchronous, active-high, bouncing.
REQ-006 btn_clear  input  1  raw clear pushbutton, asynchronous, active-high, bouncing.
REQ-007 start  output  1  run level to the downstream countup timer; 1 while counting.
REQ-008 clr_pulse  output  1  one-cycle active-high pulse instructing the downstream timer to zero its count.
REQ-009 state  output  2  current FSM state, for status LEDs and debug.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 The debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any reversion before then restarts the count at 0.
REQ-012 A press event SHALL be a single-cycle pulse on the 0->1 transition of the debounced level; the release transition generates no event.
REQ-013 A button held indefinitely SHALL generate exactly one press event.
REQ-014 FSM states: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2; encoding 2'd3 is illegal and SHALL return to IDLE on the next clk.
REQ-015 Start event transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-016 Clear event transitions: any state->IDLE, with clr_pulse asserted for exactly one cycle in the cycle after the event.
REQ-017 If start and clear events occur in the same cycle, clear SHALL win: the FSM goes to IDLE, clr_pulse fires, and the start event is discarded.
REQ-018 start SHALL be registered and equal 1 exactly when state==RUN; it SHALL update in the same cycle as state.
REQ-019 Latency from the first stable synchronized level to the state/start update SHALL be DEBOUNCE_CYCLES+1 clk cycles, fixed and independent of state.
REQ-020 Debounce counters SHALL saturate and never wrap; they hold at 0 while input and debounced level agree.
REQ-021 A clear event while in IDLE SHALL still produce clr_pulse.

Reset
REQ-022 While reset==0: synchronizer flops=0, debounced levels=0, counters=0, state=IDLE, start=0, clr_pulse=0.
REQ-023 Reset assertion SHALL take effect asynchronously; deassertion SHALL be used synchronously to clk (external reset synchronizer assumed upstream of the block).
REQ-024 A button already held through reset deassertion SHALL produce one press event after DEBOUNCE_CYCLES, because the debounced level restarts from 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; no event is generated for that press.

Structure
REQ-026 Shared package timer_pkg SHALL hold the state encoding constants (IDLE, RUN, PAUSE) and the default DEBOUNCE_CYCLES; the downstream countup decodes state using the same package.
REQ-027 One sub-module, btn_debounce (synchronizer, counter, debounced level, rising-edge pulse; parameters DEBOUNCE_CYCLES and CNT_W), SHALL be instantiated twice.
REQ-028 The FSM and output registers SHALL live in timer_btn_ctrl; there are no combinational paths from inputs to outputs.

Verification (bench uses DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-029 Reset low, then hold btn_start=1 for 20 cycles -> start goes high exactly 7 cycles after btn_start rises (2 sync + 4 debounce + 1 register); state=1; a single event only.
REQ-030 From RUN, apply bounce 1,0,1,0 at 1-cycle intervals, then a stable 1 -> one transition to PAUSE (state=2, start=0) with no intermediate toggles.
REQ-031 From PAUSE, press btn_start -> RUN; press btn_clear -> state=0, start=0, clr_pulse high for exactly 1 cycle.
REQ-032 Raise btn_start and btn_clear on the same cycle from RUN -> state=0, clr_pulse=1 for 1 cycle, and no PAUSE state visited.
REQ-033 Pull reset low 2 cycles into a btn_start debounce -> all outputs are 0 immediately; after release with the button still held, RUN is reached DEBOUNCE_CYCLES+3 cycles later.
REQ-034 Force state=3 via the bench -> IDLE on the next clk, with start=0.
